// File: rtl/step_pkg.sv
// Shared types for the step command sequencer: segment command layout,
// sequencer FSM state encoding and the reduction clamp helper.
package step_pkg;

  localparam int STEP_RED_W = 32;
  localparam int STEP_CNT_W = 31;

  typedef struct packed {
    logic [STEP_RED_W-1:0] reduction;
    logic [STEP_CNT_W-1:0] count;
    logic                  dir;
  } step_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SETUP = 3'd2,
    ST_START = 3'd3,
    ST_GUARD = 3'd4,
    ST_RUN   = 3'd5
  } step_state_e;

  // A zero half-period would stall the generator, so it is forced to one cycle.
  function automatic logic [STEP_RED_W-1:0] clampReduction(input logic [STEP_RED_W-1:0] r);
    return (r == '0) ? STEP_RED_W'(1) : r;
  endfunction

endpackage

// File: rtl/step_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO holding queued segment commands.
// flush clears everything in one cycle and wins over a simultaneous push.
module step_cmd_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [AW:0]   level_q, level_d;
  logic          doPush;
  logic          doPop;

  assign full   = (level_q == (AW+1)'(DEPTH));
  assign empty  = (level_q == '0);
  assign level  = level_q;
  assign dout   = mem[rdPtr_q];
  assign doPush = push & ~full & ~flush;
  assign doPop  = pop & ~empty;

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    level_d = level_q;
    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      level_d = '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + AW'(1);
      if (doPop)  rdPtr_d = rdPtr_q + AW'(1);
      case ({doPush, doPop})
        2'b10:   level_d = level_q + (AW+1)'(1);
        2'b01:   level_d = level_q - (AW+1)'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr_q] <= din;
  end

endmodule

// File: rtl/step_cmd_sequencer.sv
// Replays queued motion segments into the step pulse generator: load operands,
// honour direction setup time, pulse the generator start, wait for finish.
module step_cmd_sequencer
  import step_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIR_SETUP  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [STEP_RED_W-1:0]       cmd_reduction,
  input  logic [STEP_CNT_W-1:0]       cmd_count,
  input  logic                        cmd_dir,
  input  logic                        flush,
  output logic [STEP_RED_W-1:0]       gen_reduction,
  output logic [STEP_CNT_W-1:0]       gen_count,
  output logic                        gen_reset,
  input  logic                        gen_finish,
  output logic                        dir,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [15:0]                 seg_done
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = (DIR_SETUP > 1) ? $clog2(DIR_SETUP) : 1;

  step_state_e           state_q, state_d;
  logic [STEP_RED_W-1:0] genRed_q, genRed_d;
  logic [STEP_CNT_W-1:0] genCnt_q, genCnt_d;
  logic                  dir_q, dir_d;
  logic [SW-1:0]         setupCnt_q, setupCnt_d;
  logic [15:0]           segDone_q, segDone_d;

  step_cmd_t             pushCmd;
  step_cmd_t             headCmd;
  logic                  fifoFull;
  logic                  fifoEmpty;
  logic [LW-1:0]         fifoLevel;
  logic                  hasQueued;
  logic                  moreQueued;

  assign pushCmd = '{reduction: cmd_reduction, count: cmd_count, dir: cmd_dir};

  step_cmd_fifo #(
    .W    ($bits(step_cmd_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (cmd_valid),
    .pop  (state_q == ST_LOAD),
    .flush(flush),
    .din  (pushCmd),
    .dout (headCmd),
    .full (fifoFull),
    .empty(fifoEmpty),
    .level(fifoLevel)
  );

  // A flush this cycle means nothing will be left to fetch next cycle.
  assign hasQueued  = ~fifoEmpty & ~flush;
  assign moreQueued = (fifoLevel > LW'(1)) & ~flush;

  always_comb begin
    state_d    = state_q;
    genRed_d   = genRed_q;
    genCnt_d   = genCnt_q;
    dir_d      = dir_q;
    setupCnt_d = setupCnt_q;
    segDone_d  = segDone_q;
    case (state_q)
      ST_IDLE: if (hasQueued) state_d = ST_LOAD;
      ST_LOAD: begin
        genRed_d = clampReduction(headCmd.reduction);
        genCnt_d = headCmd.count;
        if (headCmd.count == '0) begin
          state_d = moreQueued ? ST_LOAD : ST_IDLE;
        end else if (headCmd.dir != dir_q) begin
          dir_d      = headCmd.dir;
          setupCnt_d = SW'(DIR_SETUP - 1);
          state_d    = ST_SETUP;
        end else begin
          state_d = ST_START;
        end
      end
      ST_SETUP: begin
        if (setupCnt_q == '0) state_d = ST_START;
        else                  setupCnt_d = setupCnt_q - SW'(1);
      end
      ST_START: state_d = ST_GUARD;
      // The generator's finish flag is stale until its start pulse has settled.
      ST_GUARD: state_d = ST_RUN;
      ST_RUN: begin
        if (gen_finish) begin
          segDone_d = segDone_q + 16'd1;
          state_d   = hasQueued ? ST_LOAD : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      genRed_q   <= STEP_RED_W'(1);
      genCnt_q   <= '0;
      dir_q      <= 1'b0;
      setupCnt_q <= '0;
      segDone_q  <= '0;
    end else begin
      state_q    <= state_d;
      genRed_q   <= genRed_d;
      genCnt_q   <= genCnt_d;
      dir_q      <= dir_d;
      setupCnt_q <= setupCnt_d;
      segDone_q  <= segDone_d;
    end
  end

  assign cmd_ready     = ~fifoFull;
  assign gen_reduction = genRed_q;
  assign gen_count     = genCnt_q;
  assign gen_reset     = (state_q == ST_START);
  assign dir           = dir_q;
  assign busy          = (state_q != ST_IDLE);
  assign fifo_level    = fifoLevel;
  assign seg_done      = segDone_q;

endmodule

// File: tb/tb_step_cmd_sequencer.sv
// Randomized and directed bench for step_cmd_sequencer with a behavioural
// step generator and a segment-timeline reference model.
module tb_step_cmd_sequencer;

  localparam int DEPTH = 8;
  localparam int SETUP = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_reduction;
  logic [30:0] cmd_count;
  logic        cmd_dir;
  logic        flush;
  logic [31:0] gen_reduction;
  logic [30:0] gen_count;
  logic        gen_reset;
  logic        gen_finish;
  logic        dir;
  logic        busy;
  logic [3:0]  fifo_level;
  logic [15:0] seg_done;

  always #5 clk = ~clk;

  step_cmd_sequencer #(.FIFO_DEPTH(DEPTH), .DIR_SETUP(SETUP)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_reduction(cmd_reduction),
    .cmd_count    (cmd_count),
    .cmd_dir      (cmd_dir),
    .flush        (flush),
    .gen_reduction(gen_reduction),
    .gen_count    (gen_count),
    .gen_reset    (gen_reset),
    .gen_finish   (gen_finish),
    .dir          (dir),
    .busy         (busy),
    .fifo_level   (fifo_level),
    .seg_done     (seg_done)
  );

  int vectors = 0;
  int miscompares = 0;
  int cycleNo = 0;
  int startPulses = 0;
  int risingEdges = 0;
  logic sawFull = 1'b0;

  always @(posedge clk) cycleNo <= cycleNo + 1;
  always @(posedge clk) if (gen_reset === 1'b1) startPulses <= startPulses + 1;
  always @(negedge clk) if (fifo_level == 4'd8 && cmd_ready == 1'b0) sawFull <= 1'b1;

  // Behavioural clk_gen: count steps of 2*reduction cycles each, then raise finish.
  logic   genActive;
  logic   clkOut;
  longint genT;
  longint genTotal;

  always @(posedge clk) begin
    if (reset) begin
      genActive <= 1'b0; gen_finish <= 1'b0; clkOut <= 1'b0; genT <= 0;
    end else if (gen_reset) begin
      genActive <= 1'b1; gen_finish <= 1'b0; clkOut <= 1'b0; genT <= 0;
      genTotal  <= 2 * longint'(gen_reduction) * longint'(gen_count);
    end else if (genActive) begin
      if (genT + 1 >= genTotal) begin
        genActive <= 1'b0; gen_finish <= 1'b1; clkOut <= 1'b0;
      end else begin
        genT   <= genT + 1;
        clkOut <= (((genT + 1) / longint'(gen_reduction)) % 2) == 1;
      end
    end
  end

  always @(posedge clkOut) risingEdges <= risingEdges + 1;

  // Reference model: a queue of pending segments plus a timeline of the current one.
  typedef struct {
    longint unsigned red;
    longint unsigned cnt;
    bit              dir;
  } cmdRec_t;

  cmdRec_t         modelQ[$];
  bit              mValid = 1'b0;
  bit              mLoad;
  int              mToStart;
  int              mSince;
  longint unsigned mRed;
  longint unsigned mCnt;
  bit              mDir;
  logic [15:0]     mDone;

  task automatic modelStep();
    cmdRec_t h;
    cmdRec_t n;
    bit      pushOk;
    bit      nextLoad = 1'b0;
    int      nextToStart = -1;
    int      nextSince = -1;
    if (reset) begin
      modelQ.delete();
      mLoad = 1'b0; mToStart = -1; mSince = -1;
      mRed = 1; mCnt = 0; mDir = 1'b0; mDone = '0; mValid = 1'b1;
      return;
    end
    if (!mValid) return;
    pushOk = cmd_valid && (modelQ.size() < DEPTH);
    if (mLoad && modelQ.size() > 0) begin
      h = modelQ.pop_front();
      mRed = (h.red == 0) ? 1 : h.red;
      mCnt = h.cnt;
      if (h.cnt == 0) nextLoad = (modelQ.size() > 0) && !flush;
      else if (h.dir != mDir) begin
        mDir = h.dir;
        nextToStart = SETUP;
      end else nextToStart = 0;
    end else if (mToStart > 0) begin
      nextToStart = mToStart - 1;
    end else if (mToStart == 0) begin
      nextSince = 1;
    end else if (mSince >= 0) begin
      if (mSince >= 2 && gen_finish) begin
        mDone = mDone + 16'd1;
        nextLoad = (modelQ.size() > 0) && !flush;
      end else nextSince = (mSince >= 2) ? 2 : mSince + 1;
    end else begin
      nextLoad = (modelQ.size() > 0) && !flush;
    end
    if (flush) modelQ.delete();
    else if (pushOk) begin
      n.red = longint'(cmd_reduction); n.cnt = longint'(cmd_count); n.dir = cmd_dir;
      modelQ.push_back(n);
    end
    mLoad = nextLoad; mToStart = nextToStart; mSince = nextSince;
  endtask

  initial forever begin
    @(posedge clk);
    modelStep();
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycleNo);
    end
  endtask

  // Every-cycle comparison of all DUT outputs against the model.
  initial forever begin
    @(negedge clk);
    if (mValid) begin
      checkOutput("cmd_ready", 32'(cmd_ready), 32'(modelQ.size() < DEPTH));
      checkOutput("gen_reduction", gen_reduction, 32'(mRed));
      checkOutput("gen_count", 32'(gen_count), 32'(mCnt));
      checkOutput("gen_reset", 32'(gen_reset), 32'(mToStart == 0));
      checkOutput("dir", 32'(dir), 32'(mDir));
      checkOutput("busy", 32'(busy), 32'(mLoad || mToStart >= 0 || mSince >= 0));
      checkOutput("fifo_level", 32'(fifo_level), 32'(modelQ.size()));
      checkOutput("seg_done", 32'(seg_done), 32'(mDone));
    end
  end

  int lastPushCycle;

  // Present one command and hold it until accepted; caller sits 1 time unit after a clk edge.
  task automatic applyStimulus(input logic [31:0] red, input logic [30:0] cnt, input logic d);
    int budget = 0;
    cmd_valid = 1'b1; cmd_reduction = red; cmd_count = cnt; cmd_dir = d;
    while (!cmd_ready && budget < 500) begin
      @(posedge clk); #1;
      budget++;
    end
    checkOutput("push_accept", 32'(cmd_ready), 32'd1);
    lastPushCycle = cycleNo;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while ((busy || fifo_level != 0) && n < budget) begin stepCycles(1); n++; end
    checkOutput("drain_idle", 32'(busy), 32'd0);
  endtask

  task automatic waitStart(output int cyc);
    int n = 0;
    while (gen_reset !== 1'b1 && n < 500) begin stepCycles(1); n++; end
    checkOutput("start_seen", 32'(gen_reset), 32'd1);
    cyc = cycleNo;
  endtask

  task automatic doReset();
    reset = 1'b1;
    stepCycles(2);
    reset = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int s1, s2, dirCycle, dirBad, n, r0, p0;
    logic [15:0] base;
    reset = 1'b1; cmd_valid = 1'b0; flush = 1'b0;
    cmd_reduction = '0; cmd_count = '0; cmd_dir = 1'b0;
    @(posedge clk); #1;
    doReset();
    checkOutput("rst_gen_reduction", gen_reduction, 32'd1);
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rst_seg_done", 32'(seg_done), 32'd0);

    // Scenario 1: single segment latency and step count.
    r0 = risingEdges;
    applyStimulus(32'd2, 31'd3, 1'b0);
    waitStart(s1);
    checkOutput("s1_latency", 32'(s1 - lastPushCycle), 32'd3);
    waitIdle(200);
    checkOutput("s1_rising_edges", 32'(risingEdges - r0), 32'd3);
    checkOutput("s1_seg_done", 32'(seg_done), 32'd1);

    // Scenario 2: direction change delays the second start by the setup time.
    applyStimulus(32'd1, 31'd2, 1'b0);
    applyStimulus(32'd2, 31'd1, 1'b1);
    waitStart(s1);
    n = 0;
    while (dir !== 1'b1 && n < 200) begin stepCycles(1); n++; end
    dirCycle = cycleNo;
    waitStart(s2);
    checkOutput("s2_setup_delay", 32'(s2 - dirCycle), 32'(SETUP));
    dirBad = 0; n = 0;
    while (busy && n < 200) begin if (dir !== 1'b1) dirBad++; stepCycles(1); n++; end
    checkOutput("s2_dir_stable", 32'(dirBad), 32'd0);

    // Scenario 3: zero-count segment is dropped.
    base = seg_done; p0 = startPulses;
    applyStimulus(32'd1, 31'd1, 1'b1);
    applyStimulus(32'd3, 31'd0, 1'b1);
    applyStimulus(32'd1, 31'd2, 1'b1);
    waitIdle(300);
    checkOutput("s3_seg_delta", 32'(16'(seg_done - base)), 32'd2);
    checkOutput("s3_start_pulses", 32'(startPulses - p0), 32'd2);

    // Scenario 4: overfill while a long segment runs.
    base = seg_done;
    applyStimulus(32'd3, 31'd4, 1'b0);
    for (int i = 0; i < 9; i++)
      applyStimulus(32'($urandom_range(1, 2)), 31'($urandom_range(1, 3)), 1'b0);
    checkOutput("s4_full_seen", 32'(sawFull), 32'd1);
    waitIdle(3000);
    checkOutput("s4_seg_delta", 32'(16'(seg_done - base)), 32'd10);

    // Scenario 5: flush with five queued behind a running segment.
    base = seg_done; p0 = startPulses;
    applyStimulus(32'd3, 31'd4, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(32'd1, 31'd1, 1'b0);
    checkOutput("s5_level_before", 32'(fifo_level), 32'd5);
    flush = 1'b1;
    stepCycles(1);
    flush = 1'b0;
    checkOutput("s5_level_after", 32'(fifo_level), 32'd0);
    waitIdle(300);
    checkOutput("s5_seg_delta", 32'(16'(seg_done - base)), 32'd1);
    checkOutput("s5_start_pulses", 32'(startPulses - p0), 32'd1);

    // Scenario 6: reset while running, then a clean restart.
    applyStimulus(32'd3, 31'd4, 1'b1);
    waitStart(s1);
    stepCycles(3 + SETUP);
    reset = 1'b1;
    stepCycles(1);
    reset = 1'b0;
    checkOutput("s6_gen_reduction", gen_reduction, 32'd1);
    checkOutput("s6_gen_count", 32'(gen_count), 32'd0);
    checkOutput("s6_gen_reset", 32'(gen_reset), 32'd0);
    checkOutput("s6_dir", 32'(dir), 32'd0);
    checkOutput("s6_busy", 32'(busy), 32'd0);
    checkOutput("s6_fifo_level", 32'(fifo_level), 32'd0);
    checkOutput("s6_seg_done", 32'(seg_done), 32'd0);
    checkOutput("s6_cmd_ready", 32'(cmd_ready), 32'd1);
    applyStimulus(32'd1, 31'd2, 1'b0);
    waitIdle(200);
    checkOutput("s6_restart_done", 32'(seg_done), 32'd1);

    // Random traffic with occasional flushes, checked by the model every cycle.
    for (int i = 0; i < 600; i++) begin
      cmd_valid     = ($urandom_range(0, 3) == 0);
      cmd_reduction = 32'($urandom_range(0, 3));
      cmd_count     = 31'($urandom_range(0, 3));
      cmd_dir       = 1'($urandom_range(0, 1));
      flush         = ($urandom_range(0, 49) == 0);
      stepCycles(1);
    end
    cmd_valid = 1'b0; flush = 1'b0;
    waitIdle(3000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
